// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the reset release sequencer: register map, restart key, FSM encoding.
package rst_seq_ctrl_pkg;

    localparam logic [7:0]  AddrCtrl = 8'h00;
    localparam logic [7:0]  AddrGap  = 8'h04;
    localparam logic [7:0]  AddrHold = 8'h08;
    localparam logic [7:0]  AddrStat = 8'h0C;

    localparam logic [31:0] SeqKey   = 32'h5EC0_0001;

    localparam int unsigned IdxW     = 3;

    typedef enum logic [1:0] {
        StAssert  = 2'd0,
        StRelease = 2'd1,
        StDone    = 2'd2,
        StIdle    = 2'd3
    } seq_state_e;

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// APB slave bus bundle for the reset sequencer (zero wait-state, 8-bit address).
interface rst_seq_ctrl_if;

    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );

endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset release sequencer: holds N_DOM domain resets, releases them in index order with a
// programmable gap; APB slave for gap, hold mask, keyed restart and status.
module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int unsigned         N_DOM   = 4,
    parameter int unsigned         CNT_W   = 8,
    parameter logic [CNT_W-1:0]    DEF_GAP = 8'd16
) (
    input  logic              pclk,
    input  logic              prst,
    rst_seq_ctrl_if.slave     apb,
    input  logic              sys_rst_n,
    output logic [N_DOM-1:0]  dom_rst_n,
    output logic              seq_busy,
    output logic              seq_done
);

    logic             wr_en, rd_en, restart;
    logic [CNT_W-1:0] gap_q, geff, cnt_q, cnt_d;
    logic [N_DOM-1:0] hold_q, rel_q, rel_d, dom_q;
    logic [IdxW-1:0]  idx_q, idx_d;
    seq_state_e       state_q, state_d;

    assign wr_en   = apb.psel & apb.pwrite & apb.penable;
    assign rd_en   = apb.psel & ~apb.pwrite & apb.penable;
    assign restart = wr_en && (apb.paddr == AddrCtrl) && (apb.pwdata == SeqKey);
    assign apb.pready = 1'b1;

    // A programmed gap of 0 behaves as a gap of 1.
    assign geff = (gap_q == '0) ? CNT_W'(1) : gap_q;

    always_ff @(posedge pclk) begin
        if (prst) begin
            gap_q  <= DEF_GAP;
            hold_q <= '0;
        end else if (wr_en) begin
            case (apb.paddr)
                AddrGap:  gap_q  <= apb.pwdata[CNT_W-1:0];
                AddrHold: hold_q <= apb.pwdata[N_DOM-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        apb.prdata = '0;
        if (rd_en) begin
            case (apb.paddr)
                AddrGap:  apb.prdata[CNT_W-1:0] = gap_q;
                AddrHold: apb.prdata[N_DOM-1:0] = hold_q;
                AddrStat: begin
                    apb.prdata[9:8] = state_q;
                    apb.prdata[6:4] = idx_q;
                    apb.prdata[0]   = seq_busy;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q <= StAssert;
            cnt_q   <= DEF_GAP;
            idx_q   <= '0;
            rel_q   <= '0;
            dom_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rel_q   <= rel_d;
            // Hold mask is applied on top of the release vector being registered this cycle.
            dom_q   <= rel_d & ~hold_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rel_d   = rel_q;
        if (!sys_rst_n || restart) begin
            state_d = StAssert;
            cnt_d   = geff;
            rel_d   = '0;
        end else begin
            unique case (state_q)
                StAssert: begin
                    rel_d = '0;
                    if (cnt_q == CNT_W'(1)) begin
                        idx_d   = '0;
                        cnt_d   = geff;
                        state_d = StRelease;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StRelease: begin
                    for (int unsigned i = 0; i < N_DOM; i++) begin
                        if (idx_q == IdxW'(i)) rel_d[i] = 1'b1;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        if (idx_q == IdxW'(N_DOM - 1)) begin
                            state_d = StDone;
                        end else begin
                            idx_d = idx_q + IdxW'(1);
                            cnt_d = geff;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StDone: state_d = StIdle;
                StIdle: ;
            endcase
        end
    end

    always_comb begin
        seq_busy = (state_q != StIdle);
        seq_done = (state_q == StDone);
    end

    assign dom_rst_n = dom_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: expected per-cycle outputs are queued from a timing
// model when each sequence is started and popped as the DUT runs.
module tb_rst_seq_ctrl;

    localparam int NDom = 4;

    typedef struct {
        logic [NDom-1:0] dom;
        logic            done;
        logic            busy;
    } exp_t;

    logic            pclk = 1'b0;
    logic            prst;
    logic            sys_rst_n;
    logic [NDom-1:0] dom_rst_n;
    logic            seq_busy;
    logic            seq_done;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    rst_seq_ctrl_if apb_if ();

    rst_seq_ctrl #(
        .N_DOM   (NDom),
        .CNT_W   (8),
        .DEF_GAP (8'd16)
    ) dut (
        .pclk      (pclk),
        .prst      (prst),
        .apb       (apb_if),
        .sys_rst_n (sys_rst_n),
        .dom_rst_n (dom_rst_n),
        .seq_busy  (seq_busy),
        .seq_done  (seq_done)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL timeout n_vec=%0d", n_vec);
        $fatal(1);
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic apb_idle();
        apb_if.psel    = 1'b0;
        apb_if.penable = 1'b0;
        apb_if.pwrite  = 1'b0;
        apb_if.paddr   = 8'h00;
        apb_if.pwdata  = 32'h0;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        apb_if.psel    = 1'b1;
        apb_if.pwrite  = 1'b1;
        apb_if.paddr   = a;
        apb_if.pwdata  = d;
        apb_if.penable = 1'b0;
        tick();
        apb_if.penable = 1'b1;
        tick();
        apb_idle();
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        apb_if.psel    = 1'b1;
        apb_if.pwrite  = 1'b0;
        apb_if.paddr   = a;
        apb_if.penable = 1'b0;
        tick();
        apb_if.penable = 1'b1;
        #1;
        d = apb_if.prdata;
        tick();
        apb_idle();
    endtask

    // Timing model, k counts edges from the first edge that sees sys_rst_n high in ASSERT.
    function automatic exp_t exp_at(int g, int k, logic [NDom-1:0] hm, int hs, int he);
        exp_t e;
        for (int i = 0; i < NDom; i++) begin
            e.dom[i] = (k >= (i + 1) * g) && !(hm[i] && k >= hs && k < he);
        end
        e.done = (k == (NDom + 1) * g - 1);
        e.busy = (k < (NDom + 1) * g);
        return e;
    endfunction

    task automatic push_seq(int g, int ncyc, logic [NDom-1:0] hm, int hs, int he);
        for (int k = 0; k < ncyc; k++) sb.push_back(exp_at(g, k, hm, hs, he));
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        exp_t e;
        prst = 1'b1;
        sys_rst_n = 1'b1;
        apb_idle();
        tick(); tick(); tick();
        n_vec++;
        if ({dom_rst_n, seq_done, seq_busy} !== {4'b0000, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_outputs got=%b exp=%b", {dom_rst_n, seq_done, seq_busy}, 6'b000001);
        end
        apb_read(8'h04, rd);
        n_vec++;
        if (rd !== 32'd16) begin
            n_err++;
            $display("FAIL reset_gap got=%h exp=%h", rd, 32'd16);
        end
        prst = 1'b0;
        push_seq(16, 5 * 16 + 2, '0, 0, 0);
        for (int k = 0; k < 5 * 16 + 2; k++) begin
            tick();
            e = sb.pop_front();
            n_vec++;
            if ({dom_rst_n, seq_done, seq_busy} !== {e.dom, e.done, e.busy}) begin
                n_err++;
                $display("FAIL power_on_seq k=%0d got=%b exp=%b", k,
                         {dom_rst_n, seq_done, seq_busy}, {e.dom, e.done, e.busy});
            end
        end
        apb_read(8'h0C, rd);
        n_vec++;
        if (rd !== 32'h0000_0330) begin
            n_err++;
            $display("FAIL stat_idle got=%h exp=%h", rd, 32'h0000_0330);
        end
    endtask

    task automatic test_restart();
        exp_t e;
        apb_write(8'h04, 32'd4);
        apb_write(8'h00, 32'h5EC0_0001);
        n_vec++;
        if ({dom_rst_n, seq_done, seq_busy} !== {4'b0000, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL restart_assert got=%b exp=%b", {dom_rst_n, seq_done, seq_busy}, 6'b000001);
        end
        push_seq(4, 21, '0, 0, 0);
        for (int k = 0; k < 21; k++) begin
            tick();
            e = sb.pop_front();
            n_vec++;
            if ({dom_rst_n, seq_done, seq_busy} !== {e.dom, e.done, e.busy}) begin
                n_err++;
                $display("FAIL restart_seq k=%0d got=%b exp=%b", k,
                         {dom_rst_n, seq_done, seq_busy}, {e.dom, e.done, e.busy});
            end
        end
    endtask

    task automatic test_sys_drop();
        exp_t e;
        apb_write(8'h00, 32'h5EC0_0001);
        push_seq(4, 10, '0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            e = sb.pop_front();
            n_vec++;
            if ({dom_rst_n, seq_done, seq_busy} !== {e.dom, e.done, e.busy}) begin
                n_err++;
                $display("FAIL pre_drop k=%0d got=%b exp=%b", k,
                         {dom_rst_n, seq_done, seq_busy}, {e.dom, e.done, e.busy});
            end
        end
        sys_rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if ({dom_rst_n, seq_done, seq_busy} !== {4'b0000, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL sys_low k=%0d got=%b exp=%b", k,
                         {dom_rst_n, seq_done, seq_busy}, 6'b000001);
            end
        end
        sys_rst_n = 1'b1;
        push_seq(4, 21, '0, 0, 0);
        for (int k = 0; k < 21; k++) begin
            tick();
            e = sb.pop_front();
            n_vec++;
            if ({dom_rst_n, seq_done, seq_busy} !== {e.dom, e.done, e.busy}) begin
                n_err++;
                $display("FAIL post_drop k=%0d got=%b exp=%b", k,
                         {dom_rst_n, seq_done, seq_busy}, {e.dom, e.done, e.busy});
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        apb_write(8'h00, 32'h5EC0_0001);
        // HOLD=0100 sampled at edge 5 (masks from edge 6), cleared at edge 17 (unmasks at 18).
        push_seq(4, 21, 4'b0100, 6, 18);
        for (int k = 0; k < 21; k++) begin
            if (k == 4 || k == 16) begin
                apb_if.psel    = 1'b1;
                apb_if.pwrite  = 1'b1;
                apb_if.paddr   = 8'h08;
                apb_if.pwdata  = (k == 4) ? 32'h4 : 32'h0;
                apb_if.penable = 1'b0;
            end else if (k == 5 || k == 17) begin
                apb_if.penable = 1'b1;
            end else begin
                apb_idle();
            end
            tick();
            e = sb.pop_front();
            n_vec++;
            if ({dom_rst_n, seq_done, seq_busy} !== {e.dom, e.done, e.busy}) begin
                n_err++;
                $display("FAIL hold_seq k=%0d got=%b exp=%b", k,
                         {dom_rst_n, seq_done, seq_busy}, {e.dom, e.done, e.busy});
            end
        end
        apb_idle();
    endtask

    task automatic test_key_gap0();
        logic [31:0] rd;
        exp_t e;
        apb_write(8'h00, 32'h1234_5678);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++;
            if ({dom_rst_n, seq_done, seq_busy} !== {4'b1111, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL bad_key k=%0d got=%b exp=%b", k,
                         {dom_rst_n, seq_done, seq_busy}, 6'b111100);
            end
        end
        apb_write(8'h04, 32'd0);
        apb_read(8'h04, rd);
        n_vec++;
        if (rd !== 32'd0) begin
            n_err++;
            $display("FAIL gap0_readback got=%h exp=%h", rd, 32'd0);
        end
        apb_write(8'h00, 32'h5EC0_0001);
        push_seq(1, 7, '0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            tick();
            e = sb.pop_front();
            n_vec++;
            if ({dom_rst_n, seq_done, seq_busy} !== {e.dom, e.done, e.busy}) begin
                n_err++;
                $display("FAIL gap0_seq k=%0d got=%b exp=%b", k,
                         {dom_rst_n, seq_done, seq_busy}, {e.dom, e.done, e.busy});
            end
        end
    endtask

    task automatic test_stat_read();
        logic [31:0] rd;
        logic [31:0] exp_stat;
        exp_t e;
        apb_write(8'h04, 32'd4);
        apb_write(8'h00, 32'h5EC0_0001);
        push_seq(4, 21, '0, 0, 0);
        for (int k = 0; k < 21; k++) begin
            tick();
            e = sb.pop_front();
            n_vec++;
            if ({dom_rst_n, seq_done, seq_busy} !== {e.dom, e.done, e.busy}) begin
                n_err++;
                $display("FAIL stat_seq k=%0d got=%b exp=%b", k,
                         {dom_rst_n, seq_done, seq_busy}, {e.dom, e.done, e.busy});
            end
            n_vec++;
            if (apb_if.prdata !== 32'h0 || apb_if.pready !== 1'b1) begin
                n_err++;
                $display("FAIL idle_bus k=%0d got=%h/%b exp=00000000/1", k,
                         apb_if.prdata, apb_if.pready);
            end
            if (k == 9) begin
                // Read STAT combinationally between edges so the sequence timing is untouched.
                exp_stat = 32'h0000_0101 | (32'((k + 1) / 4 - 1) << 4);
                apb_if.psel    = 1'b1;
                apb_if.pwrite  = 1'b0;
                apb_if.paddr   = 8'h0C;
                apb_if.penable = 1'b1;
                #1;
                n_vec++;
                if (apb_if.prdata !== exp_stat) begin
                    n_err++;
                    $display("FAIL stat_mid got=%h exp=%h", apb_if.prdata, exp_stat);
                end
                apb_idle();
            end
        end
        apb_read(8'h10, rd);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL unmapped_read got=%h exp=%h", rd, 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_restart();
        test_sys_drop();
        test_hold();
        test_key_gap0();
        test_stat_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
